// File: rtl/led_sequencer_pkg.sv
// rtl/led_sequencer_pkg.sv - shared mode encoding for the LED sequencer
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// rtl/led_sequencer_tick_gen.sv - prescaler producing a one-cycle tick every period clocks
// step is the combinational "tick is being registered now" flag for same-edge consumers.
module led_sequencer_tick_gen #(
  parameter int CNT_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 clear,
  output logic                 step,
  output logic                 tick
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] limit;

  // period 0 behaves as 1; >= lets a shortened period fire immediately
  always_comb begin
    limit = (period == '0) ? '0 : period - CNT_WIDTH'(1);
    step  = en && !clear && (cnt >= limit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt >= limit) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - N-channel LED pattern sequencer (toggle, chase, bounce, fill)
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter  int N_LEDS    = 4,
  parameter  int CNT_WIDTH = 25,
  localparam int POS_W     = $clog2(N_LEDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 dir,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [N_LEDS-1:0]    led,
  output logic [POS_W-1:0]     pos,
  output logic                 tick
);

  if (N_LEDS < 2) begin : g_bad_n_leds
    $error("led_sequencer: N_LEDS must be >= 2");
  end

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] ONE_LED  = N_LEDS'(1);

  mode_e             mode_q;
  logic              bounce_up;
  logic              fill;
  logic              mode_change;
  logic              step;
  logic              at_end;
  logic [POS_W-1:0]  pos_adv;
  logic [POS_W-1:0]  pos_next;
  logic [N_LEDS-1:0] led_next;
  logic              bounce_up_next;
  logic              fill_next;

  assign mode_change = (mode != mode_q);

  led_sequencer_tick_gen #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .period (period),
    .clear  (mode_change),
    .step   (step),
    .tick   (tick)
  );

  always_comb begin
    at_end = dir ? (pos == '0) : (pos == LAST_POS);
    if (dir) begin
      pos_adv = at_end ? LAST_POS : pos - POS_W'(1);
    end else begin
      pos_adv = at_end ? '0 : pos + POS_W'(1);
    end

    led_next       = led;
    pos_next       = pos_adv;
    bounce_up_next = bounce_up;
    fill_next      = fill;

    case (mode_q)
      MODE_TOGGLE: led_next[pos] = ~led[pos];
      MODE_CHASE:  led_next = ONE_LED << pos;
      MODE_BOUNCE: begin
        // turn around at either end without lighting the end LED twice
        led_next = ONE_LED << pos;
        if (bounce_up) begin
          if (pos == LAST_POS) begin
            pos_next       = pos - POS_W'(1);
            bounce_up_next = 1'b0;
          end else begin
            pos_next = pos + POS_W'(1);
          end
        end else if (pos == '0) begin
          pos_next       = pos + POS_W'(1);
          bounce_up_next = 1'b1;
        end else begin
          pos_next = pos - POS_W'(1);
        end
      end
      MODE_FILL: begin
        led_next[pos] = fill;
        if (at_end) fill_next = ~fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led       <= '0;
      pos       <= '0;
      bounce_up <= 1'b1;
      fill      <= 1'b1;
      mode_q    <= mode_e'(mode);
    end else if (mode_change) begin
      led       <= '0;
      pos       <= '0;
      bounce_up <= 1'b1;
      fill      <= 1'b1;
      mode_q    <= mode_e'(mode);
    end else if (step) begin
      led       <= led_next;
      pos       <= pos_next;
      bounce_up <= bounce_up_next;
      fill      <= fill_next;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed pattern checks plus randomized run against a behavioural model
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int CW = 25;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b1;
  logic [1:0]    mode   = 2'b01;
  logic          dir    = 1'b0;
  logic [CW-1:0] period = CW'(3);
  logic [N-1:0]  led;
  logic [1:0]    pos;
  logic          tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_sequencer #(
    .N_LEDS    (N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .dir    (dir),
    .period (period),
    .led    (led),
    .pos    (pos),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counts enabled cycles, pos moves modulo N, bounce from a phase index.
  int           m_cnt  = 0;
  logic         m_tick = 1'b0;
  logic [N-1:0] m_led  = '0;
  int           m_pos  = 0;
  int           m_k    = 0;
  logic         m_fill = 1'b1;
  logic [1:0]   m_mode = 2'b01;

  function automatic int adv(input int p, input logic d);
    return d ? (p + N - 1) % N : (p + 1) % N;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int lim;
    int p;
    if (!rst_n || mode != m_mode) begin
      m_cnt = 0; m_tick = 1'b0; m_led = '0; m_pos = 0; m_k = 0; m_fill = 1'b1; m_mode = mode;
    end else if (!en) begin
      m_tick = 1'b0;
    end else begin
      lim = (period == 0) ? 1 : int'(period);
      if (m_cnt >= lim - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        p      = m_pos;
        case (m_mode)
          2'b00: begin m_led[p] = ~m_led[p]; m_pos = adv(p, dir); end
          2'b01: begin m_led = N'(1) << p; m_pos = adv(p, dir); end
          2'b10: begin
            m_led = N'(1) << p;
            m_k   = (m_k + 1) % (2 * N - 2);
            m_pos = (m_k < N) ? m_k : 2 * N - 2 - m_k;
          end
          default: begin
            m_led[p] = m_fill;
            if ((!dir && p == N - 1) || (dir && p == 0)) m_fill = ~m_fill;
            m_pos = adv(p, dir);
          end
        endcase
      end else begin
        m_cnt++;
        m_tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model", 32'({led, pos, tick}), 32'({m_led, 2'(m_pos), m_tick}));
  end

  logic [N-1:0] exp_q[$];

  task automatic run_ticks(input string name, input bit jitter_dir);
    foreach (exp_q[i]) begin
      int waited;
      waited = 0;
      do begin
        @(negedge clk);
        if (jitter_dir) dir = 1'($urandom);
        waited++;
      end while (!tick && waited < 20);
      if (!tick) check({name, "_timeout"}, 32'(tick), 32'(1));
      else check(name, 32'(led), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (10) @(negedge clk);
    check("rst_led", 32'(led), 0);
    check("rst_pos", 32'(pos), 0);
    check("rst_tick", 32'(tick), 0);
    rst_n = 1'b1;
    @(negedge clk); check("first_tick_c1", 32'(tick), 0);
    @(negedge clk); check("first_tick_c2", 32'(tick), 0);
    @(negedge clk); check("first_tick_c3", 32'(tick), 1);
    check("chase_t1", 32'(led), 32'(4'b0001));

    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    run_ticks("chase", 1'b0);
    check("chase_pos_wrap", 32'(pos), 0);
    dir = 1'b1;
    exp_q = '{4'b0001};
    run_ticks("chase_dir1", 1'b0);
    check("chase_dir1_pos", 32'(pos), 3);
    dir = 1'b0;

    mode = 2'b00;
    @(negedge clk);
    check("mode_clear", 32'({led, pos, tick}), 0);
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    run_ticks("toggle", 1'b0);

    mode = 2'b10;
    @(negedge clk);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    run_ticks("bounce", 1'b1);
    dir = 1'b0;

    mode = 2'b11;
    @(negedge clk);
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    run_ticks("fill", 1'b0);
    check("fill_pos", 32'(pos), 1);

    mode = 2'b01;
    @(negedge clk);
    check("switch_clear", 32'({led, pos, tick}), 0);
    exp_q = '{4'b0001, 4'b0010};
    run_ticks("chase2", 1'b0);

    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("freeze", 32'({led, pos, tick}), 32'({4'b0010, 2'd2, 1'b0}));
    end
    en = 1'b1;
    exp_q = '{4'b0100};
    run_ticks("resume", 1'b0);

    period = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("period0_tick", 32'(tick), 1);
    end
    check("period0_led", 32'(led), 32'(4'b0001));
    period = CW'(3);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({led, pos, tick}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) mode = 2'($urandom);
      if ($urandom_range(9) == 0) dir = ~dir;
      if ($urandom_range(14) == 0) en = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) period = CW'($urandom_range(5));
      if ($urandom_range(299) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_rst", 32'({led, pos, tick}), 0);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
